// File: rtl/instr_fetch.sv
// Instruction fetch unit: reads a 1..3 byte instruction from program memory one
// byte at a time and presents it to the sequencer with a one-cycle valid pulse.
module instr_fetch #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        fetch,
    input  logic        pc_load,
    input  logic [15:0] pc_new,
    input  logic [1:0]  op_len,
    input  logic [7:0]  rom_data,
    output logic        rom_rd,
    output logic [15:0] rom_addr,
    output logic [15:0] pc,
    output logic [7:0]  opcode,
    output logic [7:0]  operand1,
    output logic [7:0]  operand2,
    output logic        instr_valid,
    output logic        busy
);

    typedef enum logic [3:0] {
        IDLE, RD_OP, CAP_OP, CHK, RD_B1, CAP_B1, RD_B2, CAP_B2, DONE
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [7:0]  opcode_q, opcode_d;
    logic [7:0]  operand1_q, operand1_d;
    logic [7:0]  operand2_q, operand2_d;
    logic        len3_q, len3_d;
    logic        rd_req, valid_req;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            opcode_q   <= 8'h00;
            operand1_q <= 8'h00;
            operand2_q <= 8'h00;
            len3_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            opcode_q   <= opcode_d;
            operand1_q <= operand1_d;
            operand2_q <= operand2_d;
            len3_q     <= len3_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        opcode_d   = opcode_q;
        operand1_d = operand1_q;
        operand2_d = operand2_q;
        len3_d     = len3_q;
        rd_req     = 1'b0;
        valid_req  = 1'b0;
        // A load aborts whatever is in flight but keeps the last instruction visible.
        if (pc_load) begin
            state_d = IDLE;
            pc_d    = pc_new;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (fetch) state_d = RD_OP;
                end
                RD_OP: begin
                    rd_req  = 1'b1;
                    state_d = CAP_OP;
                end
                CAP_OP: begin
                    opcode_d   = rom_data;
                    operand1_d = 8'h00;
                    operand2_d = 8'h00;
                    pc_d       = pc_q + 16'd1;
                    state_d    = CHK;
                end
                CHK: begin
                    // A length of 0 is treated as a single-byte instruction.
                    len3_d  = (op_len == 2'd3);
                    state_d = (op_len >= 2'd2) ? RD_B1 : DONE;
                end
                RD_B1: begin
                    rd_req  = 1'b1;
                    state_d = CAP_B1;
                end
                CAP_B1: begin
                    operand1_d = rom_data;
                    pc_d       = pc_q + 16'd1;
                    state_d    = len3_q ? RD_B2 : DONE;
                end
                RD_B2: begin
                    rd_req  = 1'b1;
                    state_d = CAP_B2;
                end
                CAP_B2: begin
                    operand2_d = rom_data;
                    pc_d       = pc_q + 16'd1;
                    state_d    = DONE;
                end
                DONE: begin
                    valid_req = 1'b1;
                    state_d   = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign rom_rd      = rd_req & ~reset;
    assign instr_valid = valid_req & ~reset;
    assign busy        = (state_q != IDLE) & ~reset;
    assign pc          = pc_q;
    assign rom_addr    = pc_q;
    assign opcode      = opcode_q;
    assign operand1    = operand1_q;
    assign operand2    = operand2_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios plus randomized fetches checked
// against a transaction-level model of what a fetch from a given pc returns.
module tb_instr_fetch;

    localparam logic [15:0] RESET_PC = 16'h0000;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        fetch = 1'b0;
    logic        pc_load = 1'b0;
    logic [15:0] pc_new = 16'h0000;
    logic [1:0]  op_len;
    logic [7:0]  rom_data = 8'h00;
    logic        rom_rd;
    logic [15:0] rom_addr;
    logic [15:0] pc;
    logic [7:0]  opcode, operand1, operand2;
    logic        instr_valid, busy;

    logic        len_ovr_en = 1'b0;
    logic [1:0]  len_ovr = 2'd1;
    logic [7:0]  rom [0:65535];

    int checks = 0;
    int errors = 0;

    int          obs_vcyc, obs_nval, obs_rdc;
    logic [15:0] rd_q[$];
    logic [15:0] mdl_pc;

    instr_fetch #(.RESET_PC(RESET_PC)) dut (
        .clock(clock), .reset(reset), .fetch(fetch), .pc_load(pc_load),
        .pc_new(pc_new), .op_len(op_len), .rom_data(rom_data), .rom_rd(rom_rd),
        .rom_addr(rom_addr), .pc(pc), .opcode(opcode), .operand1(operand1),
        .operand2(operand2), .instr_valid(instr_valid), .busy(busy)
    );

    always #5 clock = ~clock;

    // Synchronous program memory: data appears the cycle after the read strobe.
    always @(posedge clock) if (rom_rd) rom_data <= rom[rom_addr];

    assign op_len = len_ovr_en ? len_ovr : opcode[1:0];

    function automatic int eff_len(input logic [1:0] l);
        return (l == 2'd0) ? 1 : int'(l);
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic load_pc(input logic [15:0] v);
        pc_load = 1'b1;
        pc_new  = v;
        step();
        pc_load = 1'b0;
        mdl_pc  = v;
    endtask

    // Pulses fetch and records what the DUT did over the following 11 cycles.
    task automatic do_fetch(input bit hold);
        obs_vcyc = 0; obs_nval = 0; obs_rdc = 0;
        rd_q.delete();
        fetch = 1'b1;
        step();
        fetch = hold;
        for (int c = 1; c <= 11; c++) begin
            if (c == 3) fetch = 1'b0;
            if (rom_rd) begin
                rd_q.push_back(rom_addr);
                if (obs_rdc == 0) obs_rdc = c;
            end
            if (instr_valid) begin
                obs_nval++;
                if (obs_vcyc == 0) obs_vcyc = c;
            end
            step();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; fetch = 1'b0; pc_load = 1'b0;
        step(); step();
        checks++; if (pc !== RESET_PC) begin errors++; $display("FAIL reset_pc got %h want %h", pc, RESET_PC); end
        checks++; if (rom_addr !== RESET_PC) begin errors++; $display("FAIL reset_addr got %h want %h", rom_addr, RESET_PC); end
        checks++; if ({opcode, operand1, operand2} !== 24'h0) begin errors++; $display("FAIL reset_regs got %h want 000000", {opcode, operand1, operand2}); end
        checks++; if ({rom_rd, instr_valid, busy} !== 3'b000) begin errors++; $display("FAIL reset_ctrl got %b want 000", {rom_rd, instr_valid, busy}); end
        reset  = 1'b0;
        mdl_pc = RESET_PC;
        step();
    endtask

    task automatic test_basic();
        rom[16'h0000] = 8'h04;
        len_ovr_en = 1'b1; len_ovr = 2'd1;
        do_fetch(1'b0);
        checks++; if (obs_rdc !== 1) begin errors++; $display("FAIL basic_rd_cycle got %0d want 1", obs_rdc); end
        checks++; if (rd_q.size() != 1 || rd_q[0] !== 16'h0000) begin errors++; $display("FAIL basic_rd_addrs got %0d reads want 1 read at 0000", rd_q.size()); end
        checks++; if (obs_vcyc !== 4) begin errors++; $display("FAIL basic_latency got %0d want 4", obs_vcyc); end
        checks++; if (obs_nval !== 1) begin errors++; $display("FAIL basic_pulses got %0d want 1", obs_nval); end
        checks++; if ({opcode, operand1, operand2} !== 24'h040000) begin errors++; $display("FAIL basic_instr got %h want 040000", {opcode, operand1, operand2}); end
        checks++; if (pc !== 16'h0001) begin errors++; $display("FAIL basic_pc got %h want 0001", pc); end
        mdl_pc = 16'h0001;
    endtask

    task automatic test_len3();
        rom[16'h0005] = 8'h02; rom[16'h0006] = 8'h12; rom[16'h0007] = 8'h34;
        len_ovr_en = 1'b1; len_ovr = 2'd3;
        load_pc(16'h0005);
        do_fetch(1'b0);
        checks++; if (obs_vcyc !== 8) begin errors++; $display("FAIL len3_latency got %0d want 8", obs_vcyc); end
        checks++; if ({opcode, operand1, operand2} !== 24'h021234) begin errors++; $display("FAIL len3_instr got %h want 021234", {opcode, operand1, operand2}); end
        checks++; if (pc !== 16'h0008) begin errors++; $display("FAIL len3_pc got %h want 0008", pc); end
        mdl_pc = 16'h0008;
    endtask

    task automatic test_wrap();
        rom[16'hFFFF] = 8'hA5; rom[16'h0000] = 8'h5A;
        len_ovr_en = 1'b1; len_ovr = 2'd2;
        load_pc(16'hFFFF);
        do_fetch(1'b0);
        checks++; if (rd_q.size() != 2 || rd_q[0] !== 16'hFFFF || rd_q[1] !== 16'h0000) begin errors++; $display("FAIL wrap_rd_addrs got %0d reads want FFFF,0000", rd_q.size()); end
        checks++; if ({opcode, operand1, operand2} !== 24'hA55A00) begin errors++; $display("FAIL wrap_instr got %h want a55a00", {opcode, operand1, operand2}); end
        checks++; if (pc !== 16'h0001) begin errors++; $display("FAIL wrap_pc got %h want 0001", pc); end
        checks++; if (obs_vcyc !== 6) begin errors++; $display("FAIL wrap_latency got %0d want 6", obs_vcyc); end
        mdl_pc = 16'h0001;
    endtask

    task automatic test_abort();
        int nv;
        rom[16'h0020] = 8'h77;
        len_ovr_en = 1'b1; len_ovr = 2'd3;
        load_pc(16'h0020);
        fetch = 1'b1;
        step();
        fetch = 1'b0;
        repeat (4) step();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_busy_before got %b want 1", busy); end
        pc_load = 1'b1; pc_new = 16'h0100;
        #1;
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL abort_valid_during got %b want 0", instr_valid); end
        step();
        pc_load = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_idle got busy %b want 0", busy); end
        checks++; if (pc !== 16'h0100) begin errors++; $display("FAIL abort_pc got %h want 0100", pc); end
        checks++; if ({opcode, operand1} !== 16'h7700) begin errors++; $display("FAIL abort_regs got %h want 7700", {opcode, operand1}); end
        nv = 0;
        for (int c = 0; c < 6; c++) begin
            if (instr_valid || busy || rom_rd) nv++;
            step();
        end
        checks++; if (nv !== 0) begin errors++; $display("FAIL abort_quiet got %0d active cycles want 0", nv); end
        mdl_pc = 16'h0100;
    endtask

    task automatic test_busy_reset();
        int nv;
        rom[16'h0040] = 8'h11; rom[16'h0041] = 8'h22; rom[16'h0042] = 8'h33;
        len_ovr_en = 1'b1; len_ovr = 2'd3;
        load_pc(16'h0040);
        fetch = 1'b1;
        step();
        fetch = 1'b0;
        step(); step();
        fetch = 1'b1;
        step(); step();
        fetch = 1'b0;
        step();
        checks++; if (rom_rd !== 1'b1 || rom_addr !== 16'h0042) begin errors++; $display("FAIL busyrst_rd_b2 got rd %b addr %h want 1 0042", rom_rd, rom_addr); end
        reset = 1'b1;
        step();
        checks++; if (pc !== RESET_PC) begin errors++; $display("FAIL busyrst_pc got %h want %h", pc, RESET_PC); end
        checks++; if ({opcode, operand1, operand2} !== 24'h0) begin errors++; $display("FAIL busyrst_regs got %h want 000000", {opcode, operand1, operand2}); end
        checks++; if ({rom_rd, instr_valid, busy} !== 3'b000) begin errors++; $display("FAIL busyrst_ctrl got %b want 000", {rom_rd, instr_valid, busy}); end
        reset = 1'b0;
        nv = 0;
        for (int c = 0; c < 10; c++) begin
            step();
            if (instr_valid || busy) nv++;
        end
        checks++; if (nv !== 0) begin errors++; $display("FAIL busyrst_ignored got %0d active cycles want 0", nv); end
        mdl_pc = RESET_PC;
    endtask

    task automatic test_load_fetch();
        int nv;
        pc_load = 1'b1; fetch = 1'b1; pc_new = 16'h1234;
        step();
        pc_load = 1'b0; fetch = 1'b0;
        checks++; if (pc !== 16'h1234) begin errors++; $display("FAIL loadfetch_pc got %h want 1234", pc); end
        nv = 0;
        for (int c = 0; c < 6; c++) begin
            if (rom_rd || busy) nv++;
            step();
        end
        checks++; if (nv !== 0) begin errors++; $display("FAIL loadfetch_dropped got %0d active cycles want 0", nv); end
        mdl_pc = 16'h1234;
    endtask

    task automatic test_random();
        logic [15:0] p, v, ea, exp_pc;
        logic [7:0]  e_op, e_op1, e_op2;
        int          l;
        len_ovr_en = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                v = ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'hFFFD + 16'($urandom_range(0, 2));
                load_pc(v);
                checks++; if (pc !== v) begin errors++; $display("FAIL rnd_load[%0d] got %h want %h", i, pc, v); end
            end
            p      = mdl_pc;
            e_op   = rom[p];
            l      = eff_len(e_op[1:0]);
            e_op1  = (l >= 2) ? rom[p + 16'd1] : 8'h00;
            e_op2  = (l == 3) ? rom[p + 16'd2] : 8'h00;
            exp_pc = p + 16'(l);
            do_fetch(1'($urandom_range(0, 1)));
            checks++; if (obs_vcyc !== 2 + 2 * l || obs_nval !== 1) begin errors++; $display("FAIL rnd_valid[%0d] got cycle %0d pulses %0d want cycle %0d pulses 1", i, obs_vcyc, obs_nval, 2 + 2 * l); end
            checks++; if ({opcode, operand1, operand2} !== {e_op, e_op1, e_op2}) begin errors++; $display("FAIL rnd_instr[%0d] got %h want %h", i, {opcode, operand1, operand2}, {e_op, e_op1, e_op2}); end
            checks++; if (pc !== exp_pc) begin errors++; $display("FAIL rnd_pc[%0d] got %h want %h", i, pc, exp_pc); end
            checks++; if (rd_q.size() != l) begin errors++; $display("FAIL rnd_nreads[%0d] got %0d want %0d", i, rd_q.size(), l); end
            for (int k = 0; k < rd_q.size() && k < 3; k++) begin
                ea = p + 16'(k);
                checks++; if (rd_q[k] !== ea) begin errors++; $display("FAIL rnd_addr[%0d.%0d] got %h want %h", i, k, rd_q[k], ea); end
            end
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rnd_idle[%0d] got busy %b want 0", i, busy); end
            mdl_pc = exp_pc;
        end
    endtask

    initial begin
        for (int a = 0; a < 65536; a++) rom[a] = 8'($urandom);
        mdl_pc = RESET_PC;
        test_reset();
        test_basic();
        test_len3();
        test_wrap();
        test_abort();
        test_busy_reset();
        test_load_fetch();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 16'h0000, giving the program counter value loaded on reset.
REQ-002 The block SHALL have port clock, input, 1 bit: the system clock; all state changes occur on the rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port fetch, input, 1 bit: fetch request strobe from the sequencer.
REQ-005 The block SHALL have port pc_load, input, 1 bit: program counter load request (jump/branch/interrupt vector).
REQ-006 The block SHALL have port pc_new, input, 16 bits: value loaded into pc when pc_load is high.
REQ-007 The block SHALL have port op_len, input, 2 bits: instruction length in bytes, combinationally derived externally from the opcode output.
REQ-008 The block SHALL have port rom_data, input, 8 bits: program memory read data, valid the cycle after rom_rd.
REQ-009 The block SHALL have port rom_rd, output, 1 bit: program memory read strobe.
REQ-010 The block SHALL have port rom_addr, output, 16 bits: program memory address, always equal to pc.
REQ-011 The block SHALL have port pc, output, 16 bits: current program counter.
REQ-012 The block SHALL have port opcode, output, 8 bits: last fetched opcode, feeding the sequencer Opcode input.
REQ-013 The block SHALL have port operand1, output, 8 bits: second instruction byte.
REQ-014 The block SHALL have port operand2, output, 8 bits: third instruction byte.
REQ-015 The block SHALL have port instr_valid, output, 1 bit: one-cycle pulse when a complete instruction is held on opcode/operand1/operand2.
REQ-016 The block SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-017 The block SHALL have FSM states IDLE, RD_OP, CAP_OP, CHK, RD_B1, CAP_B1, RD_B2, CAP_B2 and DONE.
REQ-018 IDLE: fetch=1 -> RD_OP; otherwise stay in IDLE.
REQ-019 rom_rd SHALL be 1 only in RD_OP, RD_B1 and RD_B2; each of these advances unconditionally to the matching CAP state.
REQ-020 CAP_OP: opcode<=rom_data, operand1<=0, operand2<=0, pc<=pc+1; then -> CHK.
REQ-021 CHK: op_len is sampled; 1 or 0 -> DONE (0 is treated as 1); 2 or 3 -> RD_B1.
REQ-022 CAP_B1: operand1<=rom_data, pc<=pc+1; then -> RD_B2 if the length sampled in CHK was 3, else -> DONE.
REQ-023 CAP_B2: operand2<=rom_data, pc<=pc+1; then -> DONE.
REQ-024 DONE: instr_valid=1 for exactly this cycle; then -> IDLE.
REQ-025 Latency: with fetch sampled at edge E0, instr_valid SHALL be high in cycle 4, 6 or 8 after E0 for lengths 1, 2 or 3.
REQ-026 fetch asserted outside IDLE SHALL be ignored (not queued).
REQ-027 pc_load SHALL have priority in every state: pc<=pc_new, state -> IDLE, no instr_valid; an in-flight fetch is aborted; opcode/operand registers are retained.
REQ-028 pc_load and fetch high together in IDLE: the load SHALL win and the fetch is dropped.
REQ-029 pc arithmetic SHALL be modulo 2^16: 16'hFFFF+1 = 16'h0000.
REQ-030 Outputs opcode, operand1 and operand2 SHALL hold their values between fetches.

Reset
REQ-031 While reset=1, the block SHALL set state=IDLE, pc=RESET_PC, opcode=0, operand1=0, operand2=0, rom_rd=0, instr_valid=0 and busy=0; reset overrides pc_load and fetch and aborts any fetch in progress.

Verification
REQ-032 Reset, pc=0, ROM[0]=8'h04, op_len=1, fetch pulse -> rom_rd in cycle 1 with addr 0; instr_valid in cycle 4; opcode=04, operands=00, pc=1.
REQ-033 ROM[5..7]=8'h02,8'h12,8'h34, op_len=3, pc_load 5 then fetch -> instr_valid in cycle 8; opcode=02, operand1=12, operand2=34, pc=8.
REQ-034 pc=16'hFFFF, 2-byte instruction -> operand1 read from 16'h0000; final pc=16'h0001.
REQ-035 pc_load=1 with pc_new=16'h0100 in the CAP_B1 cycle -> no instr_valid; IDLE next cycle; pc=0100; opcode unchanged.
REQ-036 fetch re-asserted while busy, then reset in RD_B2 -> extra fetch ignored; after reset all outputs are at reset values and pc=RESET_PC.
REQ-037 fetch and pc_load high together in IDLE -> pc=pc_new; rom_rd stays 0; busy stays 0.
